// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth sequential signed multiplier, start/busy/done handshake.
// Define BOOTH_EARLY_EXIT_EN to finish as soon as the remaining steps are pure shifts.
module booth_mul_ctrl #(
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] product
);

  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [M:0]     acc_q, acc_d;
  logic [M:0]     mcand_q, mcand_d;
  logic [M-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*M-1:0] prod_q, prod_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [M:0]     sum;
  logic [M:0]     acc_n;
  logic [M-1:0]   q_n;
  logic           q1_n;
  logic           last;
  logic           finish;
  logic [2*M-1:0] prod_n;

`ifdef BOOTH_EARLY_EXIT_EN
  int                    rem;
  logic                  quiet;
  logic signed [2*M:0]   shifted;
`endif

  always_comb begin
    unique case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + mcand_q;
      2'b10:   sum = acc_q - mcand_q;
      default: sum = acc_q;
    endcase
    acc_n = {sum[M], sum[M:1]};
    q_n   = {sum[0], q_q[M-1:1]};
    q1_n  = q_q[0];
    last  = (cnt_q == CW'(M - 1));
`ifdef BOOTH_EARLY_EXIT_EN
    // Remaining pairs all equal: the rest is one arithmetic shift.
    rem   = M - 1 - int'(cnt_q);
    quiet = 1'b1;
    for (int i = 0; i < M; i++) begin
      if (i < rem && q_n[i] != q1_n) quiet = 1'b0;
    end
    shifted = $signed({acc_n, q_n}) >>> rem;
    finish  = last || quiet;
    prod_n  = shifted[2*M-1:0];
`else
    finish = last;
    prod_n = {acc_n[M-1:0], q_n};
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          acc_d   = '0;
          mcand_d = {a[M-1], a};
          q_d     = b;
          q1_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_n;
        q_d   = q_n;
        q1_d  = q1_n;
        cnt_d = cnt_q + CW'(1);
        if (finish) begin
          prod_d  = prod_n;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule
